// File: rtl/lexington_pkg.sv
// Shared AXI-Lite definitions for the lexington core bridge.
// Response codes, bridge state encoding and a response helper.
package lexington_pkg;

    localparam int DEFAULT_AXI_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_DONE  = 3'd5
    } bridge_state_e;

    function automatic logic resp_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_bridge.sv
// Single-outstanding core-to-AXI-Lite master bridge.
// One read or write per request; watchdog turns a hung slave into a fault.
module axi_lite_bridge
    import lexington_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      axi_rd_en,
    input  logic                      axi_wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_addr,
    input  logic [31:0]               wr_data,
    input  logic [3:0]                wr_strobe,
    output logic [31:0]               axi_rd_data,
    output logic                      axi_access_fault,
    output logic                      axi_busy,
    output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [31:0]               m_wdata,
    output logic [3:0]                m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [31:0]               m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    bridge_state_e             state;
    bridge_state_e             nxt;
    logic [AXI_ADDR_WIDTH-1:0] addr_lat;
    logic [31:0]               data_lat;
    logic [3:0]                strb_lat;
    logic [31:0]               rdata_reg;
    logic                      fault;
    logic                      aw_done;
    logic                      w_done;
    logic [CW-1:0]             cnt;
    logic                      timeout;
    logic                      aw_hs;
    logic                      w_hs;

    // Watchdog cycle masks every valid/ready so nothing handshakes late.
    assign timeout   = (cnt == CW'(TIMEOUT_CYCLES));

    assign m_awaddr  = addr_lat;
    assign m_wdata   = data_lat;
    assign m_wstrb   = strb_lat;
    assign m_araddr  = addr_lat;

    assign m_awvalid = (state == ST_WR) && !aw_done && !timeout;
    assign m_wvalid  = (state == ST_WR) && !w_done && !timeout;
    assign m_bready  = (state == ST_WRESP) && !timeout;
    assign m_arvalid = (state == ST_RADDR) && !timeout;
    assign m_rready  = (state == ST_RDATA) && !timeout;

    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;

    assign axi_rd_data      = rdata_reg;
    assign axi_access_fault = (state == ST_DONE) && fault;

    always_comb begin
        nxt      = state;
        axi_busy = 1'b1;
        unique case (state)
            ST_IDLE: begin
                axi_busy = axi_rd_en || axi_wr_en;
                if (axi_rd_en && axi_wr_en)
                    nxt = ST_DONE;
                else if (axi_wr_en)
                    nxt = ST_WR;
                else if (axi_rd_en)
                    nxt = ST_RADDR;
            end
            ST_WR: begin
                if (timeout)
                    nxt = ST_DONE;
                else if ((aw_done || aw_hs) && (w_done || w_hs))
                    nxt = ST_WRESP;
            end
            ST_WRESP: begin
                if (timeout || m_bvalid)
                    nxt = ST_DONE;
            end
            ST_RADDR: begin
                if (timeout)
                    nxt = ST_DONE;
                else if (m_arready)
                    nxt = ST_RDATA;
            end
            ST_RDATA: begin
                if (timeout || m_rvalid)
                    nxt = ST_DONE;
            end
            ST_DONE: begin
                axi_busy = 1'b0;
                nxt      = ST_IDLE;
            end
            default: begin
                axi_busy = 1'b0;
                nxt      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_lat  <= '0;
            data_lat  <= '0;
            strb_lat  <= '0;
            rdata_reg <= '0;
            fault     <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            cnt       <= '0;
        end else begin
            state <= nxt;
            unique case (state)
                ST_IDLE: begin
                    cnt     <= '0;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (axi_rd_en || axi_wr_en) begin
                        addr_lat  <= axi_addr;
                        data_lat  <= wr_data;
                        strb_lat  <= wr_strobe;
                        rdata_reg <= '0;
                        fault     <= axi_rd_en && axi_wr_en;
                    end
                end
                ST_WR: begin
                    cnt <= cnt + 1'b1;
                    if (aw_hs)
                        aw_done <= 1'b1;
                    if (w_hs)
                        w_done <= 1'b1;
                    if (timeout)
                        fault <= 1'b1;
                end
                ST_WRESP: begin
                    cnt <= cnt + 1'b1;
                    if (timeout)
                        fault <= 1'b1;
                    else if (m_bvalid)
                        fault <= resp_err(m_bresp);
                end
                ST_RADDR: begin
                    cnt <= cnt + 1'b1;
                    if (timeout)
                        fault <= 1'b1;
                end
                ST_RDATA: begin
                    cnt <= cnt + 1'b1;
                    if (timeout) begin
                        fault <= 1'b1;
                    end else if (m_rvalid) begin
                        rdata_reg <= m_rdata;
                        fault     <= resp_err(m_rresp);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_bridge.sv
// Directed bench for axi_lite_bridge with a hand-driven AXI-Lite slave.
// Watchdog is shortened to 8 cycles so the hung-slave case stays brief.
module tb_axi_lite_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        axi_rd_en;
    logic        axi_wr_en;
    logic [31:0] axi_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strobe;
    logic [31:0] axi_rd_data;
    logic        axi_access_fault;
    logic        axi_busy;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_lite_bridge #(
        .AXI_ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .axi_rd_en(axi_rd_en),
        .axi_wr_en(axi_wr_en),
        .axi_addr(axi_addr),
        .wr_data(wr_data),
        .wr_strobe(wr_strobe),
        .axi_rd_data(axi_rd_data),
        .axi_access_fault(axi_access_fault),
        .axi_busy(axi_busy),
        .m_awaddr(m_awaddr),
        .m_awvalid(m_awvalid),
        .m_awready(m_awready),
        .m_wdata(m_wdata),
        .m_wstrb(m_wstrb),
        .m_wvalid(m_wvalid),
        .m_wready(m_wready),
        .m_bresp(m_bresp),
        .m_bvalid(m_bvalid),
        .m_bready(m_bready),
        .m_araddr(m_araddr),
        .m_arvalid(m_arvalid),
        .m_arready(m_arready),
        .m_rdata(m_rdata),
        .m_rresp(m_rresp),
        .m_rvalid(m_rvalid),
        .m_rready(m_rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic no_valids(input string tag);
        chk({tag, " awvalid"}, 32'(m_awvalid), 32'd0);
        chk({tag, " wvalid"}, 32'(m_wvalid), 32'd0);
        chk({tag, " arvalid"}, 32'(m_arvalid), 32'd0);
        chk({tag, " bready"}, 32'(m_bready), 32'd0);
        chk({tag, " rready"}, 32'(m_rready), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        axi_rd_en = 0; axi_wr_en = 0; axi_addr = '0;
        wr_data = '0; wr_strobe = '0;
        m_awready = 0; m_wready = 0; m_bresp = 0; m_bvalid = 0;
        m_arready = 0; m_rdata = '0; m_rresp = 0; m_rvalid = 0;
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        smp();
        chk("rst busy", 32'(axi_busy), 32'd0);
        chk("rst fault", 32'(axi_access_fault), 32'd0);
        chk("rst rdata", axi_rd_data, 32'd0);
        no_valids("rst");

        // Zero-wait read of 0x1000
        cyc();
        m_arready = 1; m_rvalid = 1; m_rdata = 32'hCAFEF00D; m_rresp = 2'd0;
        axi_rd_en = 1; axi_addr = 32'h1000;
        smp();
        chk("rd req busy", 32'(axi_busy), 32'd1);
        chk("rd req arvalid", 32'(m_arvalid), 32'd0);
        cyc();
        axi_rd_en = 0; axi_addr = 32'hFFFF;
        smp();
        chk("rd raddr busy", 32'(axi_busy), 32'd1);
        chk("rd arvalid", 32'(m_arvalid), 32'd1);
        chk("rd araddr", m_araddr, 32'h1000);
        cyc();
        smp();
        chk("rd rdata busy", 32'(axi_busy), 32'd1);
        chk("rd rready", 32'(m_rready), 32'd1);
        chk("rd arvalid low", 32'(m_arvalid), 32'd0);
        cyc();
        smp();
        chk("rd done busy", 32'(axi_busy), 32'd0);
        chk("rd done data", axi_rd_data, 32'hCAFEF00D);
        chk("rd done fault", 32'(axi_access_fault), 32'd0);
        cyc();
        smp();
        chk("rd idle busy", 32'(axi_busy), 32'd0);
        no_valids("rd idle");
        m_arready = 0; m_rvalid = 0;

        // Write with wready 3 cycles after awready
        cyc();
        m_awready = 1; m_wready = 0;
        axi_wr_en = 1; axi_addr = 32'h2000;
        wr_data = 32'h12345678; wr_strobe = 4'hC;
        smp();
        chk("wr req busy", 32'(axi_busy), 32'd1);
        cyc();
        axi_wr_en = 0; wr_data = 32'h0; wr_strobe = 4'h0;
        smp();
        chk("wr awvalid", 32'(m_awvalid), 32'd1);
        chk("wr wvalid", 32'(m_wvalid), 32'd1);
        chk("wr awaddr", m_awaddr, 32'h2000);
        for (int i = 0; i < 2; i++) begin
            cyc();
            smp();
            chk("wr aw dropped", 32'(m_awvalid), 32'd0);
            chk("wr wvalid held", 32'(m_wvalid), 32'd1);
            chk("wr wdata held", m_wdata, 32'h12345678);
            chk("wr wstrb held", 32'(m_wstrb), 32'hC);
        end
        cyc();
        m_wready = 1;
        smp();
        chk("wr w hs wvalid", 32'(m_wvalid), 32'd1);
        chk("wr w hs wdata", m_wdata, 32'h12345678);
        cyc();
        m_wready = 0; m_bvalid = 1; m_bresp = 2'd0;
        smp();
        chk("wr bready", 32'(m_bready), 32'd1);
        chk("wr resp wvalid", 32'(m_wvalid), 32'd0);
        chk("wr resp busy", 32'(axi_busy), 32'd1);
        cyc();
        m_bvalid = 0;
        smp();
        chk("wr done busy", 32'(axi_busy), 32'd0);
        chk("wr done fault", 32'(axi_access_fault), 32'd0);
        chk("wr done rdata", axi_rd_data, 32'd0);
        cyc();
        m_awready = 0;

        // Read answered with SLVERR
        m_arready = 1; m_rvalid = 1; m_rdata = 32'hDEAD0001; m_rresp = 2'd2;
        axi_rd_en = 1; axi_addr = 32'h3000;
        cyc();
        axi_rd_en = 0;
        cyc();
        smp();
        chk("slv rdata fault", 32'(axi_access_fault), 32'd0);
        cyc();
        smp();
        chk("slv done fault", 32'(axi_access_fault), 32'd1);
        chk("slv done busy", 32'(axi_busy), 32'd0);
        cyc();
        smp();
        chk("slv after fault", 32'(axi_access_fault), 32'd0);
        m_arready = 0; m_rvalid = 0; m_rresp = 2'd0;

        // Hung slave: arready never rises
        cyc();
        axi_rd_en = 1; axi_addr = 32'h4000;
        cyc();
        axi_rd_en = 0;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk("to arvalid", 32'(m_arvalid), 32'd1);
            chk("to fault low", 32'(axi_access_fault), 32'd0);
            cyc();
        end
        smp();
        chk("to drop arvalid", 32'(m_arvalid), 32'd0);
        chk("to drop busy", 32'(axi_busy), 32'd1);
        cyc();
        smp();
        chk("to done fault", 32'(axi_access_fault), 32'd1);
        chk("to done rdata", axi_rd_data, 32'd0);
        chk("to done busy", 32'(axi_busy), 32'd0);
        cyc();

        // Conflicting read and write
        axi_rd_en = 1; axi_wr_en = 1; axi_addr = 32'h5000;
        smp();
        chk("both busy", 32'(axi_busy), 32'd1);
        no_valids("both req");
        cyc();
        axi_rd_en = 0; axi_wr_en = 0;
        smp();
        chk("both done fault", 32'(axi_access_fault), 32'd1);
        chk("both done busy", 32'(axi_busy), 32'd0);
        no_valids("both done");
        cyc();
        smp();
        no_valids("both idle");

        // Reset while waiting for the write response
        cyc();
        m_awready = 1; m_wready = 1;
        axi_wr_en = 1; axi_addr = 32'h6000; wr_data = 32'hA5A5A5A5;
        wr_strobe = 4'hF;
        cyc();
        axi_wr_en = 0;
        cyc();
        smp();
        chk("rstw bready", 32'(m_bready), 32'd1);
        cyc();
        rst = 1;
        cyc();
        rst = 0; m_awready = 0; m_wready = 0;
        m_bvalid = 1; m_bresp = 2'd2;
        smp();
        chk("rstw bready low", 32'(m_bready), 32'd0);
        chk("rstw busy", 32'(axi_busy), 32'd0);
        chk("rstw fault", 32'(axi_access_fault), 32'd0);
        no_valids("rstw idle");
        for (int i = 0; i < 3; i++) begin
            cyc();
            smp();
            chk("rstw late busy", 32'(axi_busy), 32'd0);
            chk("rstw late fault", 32'(axi_access_fault), 32'd0);
            chk("rstw late bready", 32'(m_bready), 32'd0);
        end
        m_bvalid = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
